// File: rtl/icache_resp_if.sv
// Fetch-side and refill-side signals of the instruction cache bundled into one interface.
// The slave modport is the cache; the master modport is its environment
// (fetch stage plus memory arbiter).
interface icache_resp_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        imem_stall;
  logic        flush;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;

  modport slave (
    input  imem_addr, flush, mem_req_ready, mem_rsp_valid, mem_rsp_data,
    output imem_data, imem_stall, mem_req_valid, mem_req_addr
  );

  modport master (
    output imem_addr, flush, mem_req_ready, mem_rsp_valid, mem_rsp_data,
    input  imem_data, imem_stall, mem_req_valid, mem_req_addr
  );
endinterface

// File: rtl/icache_resp.sv
// Direct-mapped read-only instruction cache.
// A hit answers in the same cycle. A miss stalls fetch and refills the whole line
// through a request/burst-response handshake.
module icache_resp #(
  parameter int LINES          = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic         clk,
  input  logic         reset,
  icache_resp_if.slave bus
);
  localparam int OFF_W = $clog2(WORDS_PER_LINE);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 30 - OFF_W - IDX_W;
  localparam int NWORD = LINES * WORDS_PER_LINE;

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, FILL = 2'd2} state_t;

  state_t             state_q, state_d;
  logic [LINES-1:0]   valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q  [LINES];
  logic [TAG_W-1:0]   tag_d  [LINES];
  logic [31:0]        data_q [NWORD];
  logic [31:0]        data_d [NWORD];
  logic [31:0]        line_addr_q, line_addr_d;
  logic [OFF_W-1:0]   cnt_q, cnt_d;
  logic               flush_pend_q, flush_pend_d;

  logic [OFF_W-1:0]   off_s;
  logic [IDX_W-1:0]   idx_s;
  logic [TAG_W-1:0]   tag_s;
  logic [IDX_W-1:0]   fill_idx_s;
  logic [TAG_W-1:0]   fill_tag_s;
  logic               hit_s;

  assign off_s      = bus.imem_addr[OFF_W+1:2];
  assign idx_s      = bus.imem_addr[OFF_W+IDX_W+1:OFF_W+2];
  assign tag_s      = bus.imem_addr[31:OFF_W+IDX_W+2];
  assign fill_idx_s = line_addr_q[OFF_W+IDX_W+1:OFF_W+2];
  assign fill_tag_s = line_addr_q[31:OFF_W+IDX_W+2];

  // Hit lookup and fetch-facing outputs; purely combinational so a hit costs no cycle.
  always_comb begin
    hit_s          = (state_q == IDLE) && valid_q[idx_s] && (tag_q[idx_s] == tag_s);
    bus.imem_stall = ~hit_s;
    if (hit_s) begin
      bus.imem_data = data_q[{idx_s, off_s}];
    end else begin
      bus.imem_data = 32'h0;
    end
    bus.mem_req_valid = (state_q == REQ);
    bus.mem_req_addr  = line_addr_q;
  end

  // Refill FSM next state plus all storage updates (valid bits, tags, line data).
  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    tag_d        = tag_q;
    data_d       = data_q;
    line_addr_d  = line_addr_q;
    cnt_d        = cnt_q;
    flush_pend_d = flush_pend_q;
    case (state_q)
      IDLE: begin
        // A flush here only clears valids; a concurrent hit has already been answered.
        if (bus.flush) begin
          valid_d = '0;
        end else begin
          valid_d = valid_q;
        end
        if (!hit_s) begin
          line_addr_d = {bus.imem_addr[31:OFF_W+2], {(OFF_W+2){1'b0}}};
          state_d     = REQ;
        end else begin
          state_d     = IDLE;
        end
      end
      REQ: begin
        if (bus.flush) begin
          flush_pend_d = 1'b1;
        end else begin
          flush_pend_d = flush_pend_q;
        end
        if (bus.mem_req_ready) begin
          cnt_d   = '0;
          state_d = FILL;
        end else begin
          state_d = REQ;
        end
      end
      FILL: begin
        if (bus.flush) begin
          flush_pend_d = 1'b1;
        end else begin
          flush_pend_d = flush_pend_q;
        end
        if (bus.mem_rsp_valid) begin
          data_d[{fill_idx_s, cnt_q}] = bus.mem_rsp_data;
          cnt_d = cnt_q + {{(OFF_W-1){1'b0}}, 1'b1};
          if (cnt_q == OFF_W'(WORDS_PER_LINE - 1)) begin
            tag_d[fill_idx_s] = fill_tag_s;
            // A flush seen at any point of the fill (even on this beat) wins over install.
            if (flush_pend_q || bus.flush) begin
              valid_d = '0;
            end else begin
              valid_d[fill_idx_s] = 1'b1;
            end
            flush_pend_d = 1'b0;
            state_d      = IDLE;
          end else begin
            state_d = FILL;
          end
        end else begin
          state_d = FILL;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control state with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      valid_q      <= '0;
      line_addr_q  <= 32'h0;
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      line_addr_q  <= line_addr_d;
      cnt_q        <= cnt_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  // Tag and data arrays carry no reset; the valid bits guard them.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end
endmodule
